imem_arbiter: RTL and testbench
===============================

Name: imem_arbiter

Overview:
- Shares the single combinational instruction memory read port between two requesters:
  - port 0: instruction fetch (if_*)
  - port 1: data-side loads from code space (ld_*), e.g. .rodata constants.
- Arbitrates, drives the memory address, captures the 32-bit little-endian word and returns it through a registered per-port response with valid/ready handshakes.
- Sits between core fetch/LSU and the instruction memory.

Parameters:
- ADDR_W, 32, address width of requests and mem_addr.
- PRIO_MODE, 0, arbitration policy:
  - 0 = round-robin.
  - 1 = fetch priority with load anti-starvation.
- STARVE_LIMIT, 4, in PRIO_MODE=1: consecutive cycles a pending load may lose before it is forced to win. Range 1..15.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- if_req_valid  in  1  fetch request valid
- if_req_ready  out  1  fetch request accepted this cycle
- if_req_addr  in  ADDR_W  fetch byte address
- if_resp_valid  out  1  fetch response valid
- if_resp_ready  in  1  fetch consumer accepts response
- if_resp_data  out  32  fetched word
- if_resp_err  out  1  fetch error flag (see Optional Feature)
- ld_req_valid / ld_req_ready / ld_req_addr / ld_resp_valid / ld_resp_ready / ld_resp_data / ld_resp_err: same as the if_* ports, for the load port
- mem_addr  out  ADDR_W  address to instruction memory
- mem_rdata  in  32  combinational read data from instruction memory

Behaviour:
- Reset (rst_n=0 at posedge):
  - both resp_valid=0, resp_data=0, resp_err=0
  - rr pointer = "last granted = ld", so fetch wins the first tie
  - starve counter = 0
- Port p is "eligible" when p_req_valid=1 and its response slot is free. Slot free: p_resp_valid=0, or p_resp_ready=1 this cycle (same-cycle drain and refill allowed).
- Grant is combinational, at most one port per cycle:
  - Only one port eligible: grant it.
  - Both eligible, PRIO_MODE=0: grant the port not granted last.
  - Both eligible, PRIO_MODE=1: grant fetch, unless starve counter == STARVE_LIMIT; then grant ld.
- p_req_ready = grant==p. A handshake occurs when p_req_valid and p_req_ready are both 1 in the same cycle.
- mem_addr = granted port's addr; 0 when no grant.
- Latency:
  - Request accepted in cycle N.
  - mem_rdata sampled at the end of cycle N into p_resp_data.
  - p_resp_valid=1 from cycle N+1.
- Response hold:
  - p_resp_valid stays 1 and p_resp_data stays stable until p_resp_ready=1.
  - At that edge p_resp_valid clears, unless a new handshake on p occurs in the same cycle, in which case it stays 1 with the new data.
- One outstanding response per port; no reordering is possible.
- rr pointer updates only on a handshake.
- Starve counter (PRIO_MODE=1 only):
  - Increments (saturating at STARVE_LIMIT) each cycle ld_req_valid=1 and ld is not granted.
  - Clears on any ld handshake, or when ld_req_valid=0.
  - Held at 0 in PRIO_MODE=0.
- Request-side rules: addr and valid must stay stable until handshake. The arbiter does not check this.
- Reset mid-operation: pending responses are discarded; no response is emitted for requests accepted in the reset cycle.
- A blocked resp_ready on one port never stalls the other port.

Optional Feature:
- Macro: IMEM_ARB_ALIGN_CHECK_EN.
- Defined:
  - An accepted request with addr[1:0] != 0 still gets a response the next cycle, with p_resp_err=1 and p_resp_data=0.
  - Memory data is ignored for that response.
  - p_resp_err has the same valid/hold rules as data.
- Not defined: resp_err ports are tied to 0, and misaligned addresses are passed to memory unchanged.

Test Plan:
- Reset then fetch only: if_req_valid=1, addr=0x8, mem returns 0x00D00593 → if_req_ready=1 in cycle 0; if_resp_valid=1, data=0x00D00593 in cycle 1; ld idle throughout.
- PRIO_MODE=0, both ports valid continuously, resp_ready=1 → grants alternate if, ld, if, ld…, starting with if after reset; mem_addr alternates between the two addresses.
- PRIO_MODE=1, STARVE_LIMIT=4, both valid continuously → fetch granted for 4 cycles, then ld granted in cycle 5; counter clears; pattern repeats (4 if : 1 ld).
- Backpressure: if_resp_ready=0 after first fetch, if_req_valid held → if_req_ready=0, if_resp_data stable; ld requests still granted every cycle; raising if_resp_ready resumes fetch with same-cycle refill.
- Reset asserted the cycle after a handshake → both resp_valid=0 the next cycle, no stale response appears after rst_n returns to 1.
- With IMEM_ARB_ALIGN_CHECK_EN: ld request addr=0x6 → ld_resp_valid=1, ld_resp_err=1, ld_resp_data=0 next cycle. Without the macro: err=0 and data = word at 0x6.

Source files
------------

// File: rtl/imem_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | Module      : imem_arbiter_if                                              |
// | Description : Fetch/load request-response channels and memory read port.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

interface imem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              if_req_valid;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_req_addr;
    logic              if_resp_valid;
    logic              if_resp_ready;
    logic [31:0]       if_resp_data;
    logic              if_resp_err;

    logic              ld_req_valid;
    logic              ld_req_ready;
    logic [ADDR_W-1:0] ld_req_addr;
    logic              ld_resp_valid;
    logic              ld_resp_ready;
    logic [31:0]       ld_resp_data;
    logic              ld_resp_err;

    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;

    // Arbiter side
    modport slave (
        input  if_req_valid, if_req_addr, if_resp_ready,
        input  ld_req_valid, ld_req_addr, ld_resp_ready,
        input  mem_rdata,
        output if_req_ready, if_resp_valid, if_resp_data, if_resp_err,
        output ld_req_ready, ld_resp_valid, ld_resp_data, ld_resp_err,
        output mem_addr
    );

    // Requester and memory side
    modport master (
        output if_req_valid, if_req_addr, if_resp_ready,
        output ld_req_valid, ld_req_addr, ld_resp_ready,
        output mem_rdata,
        input  if_req_ready, if_resp_valid, if_resp_data, if_resp_err,
        input  ld_req_ready, ld_resp_valid, ld_resp_data, ld_resp_err,
        input  mem_addr
    );
endinterface

`default_nettype wire

// File: rtl/imem_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module      : imem_arbiter                                                 |
// | Description : Shares the instruction memory read port between fetch and   |
// |               code-space loads; registered per-port responses.             |
// |               Optional macro IMEM_ARB_ALIGN_CHECK_EN flags misaligned      |
// |               requests with resp_err=1 and zero data.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module imem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int PRIO_MODE    = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  wire            clk,
    input  wire            rst_n,
    imem_arbiter_if.slave  bus
);

    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_LIMIT);
`ifdef IMEM_ARB_ALIGN_CHECK_EN
    localparam bit c_ALIGN_CHECK = 1'b1;
`else
    localparam bit c_ALIGN_CHECK = 1'b0;
`endif

    logic              r_if_resp_valid;
    logic [31:0]       r_if_resp_data;
    logic              r_if_resp_err;
    logic              r_ld_resp_valid;
    logic [31:0]       r_ld_resp_data;
    logic              r_ld_resp_err;
    logic              r_last_ld;
    logic [3:0]        r_starve;

    logic              w_if_elig;
    logic              w_ld_elig;
    logic              w_gnt_if;
    logic              w_gnt_ld;
    logic              w_if_misalign;
    logic              w_ld_misalign;
    logic [ADDR_W-1:0] w_mem_addr;

    // A port may take a new request when its response slot drains this cycle.
    always_comb begin
        w_if_elig = bus.if_req_valid && (!r_if_resp_valid || bus.if_resp_ready);
        w_ld_elig = bus.ld_req_valid && (!r_ld_resp_valid || bus.ld_resp_ready);
        w_gnt_if  = 1'b0;
        w_gnt_ld  = 1'b0;
        if (w_if_elig && w_ld_elig) begin
            if (PRIO_MODE == 0) begin
                w_gnt_ld = !r_last_ld;
            end else begin
                w_gnt_ld = (r_starve == c_STARVE_MAX);
            end
            w_gnt_if = !w_gnt_ld;
        end else begin
            w_gnt_if = w_if_elig;
            w_gnt_ld = w_ld_elig;
        end
    end

    always_comb begin
        w_mem_addr = '0;
        if (w_gnt_if) begin
            w_mem_addr = bus.if_req_addr;
        end else if (w_gnt_ld) begin
            w_mem_addr = bus.ld_req_addr;
        end
    end

    assign w_if_misalign = c_ALIGN_CHECK && (bus.if_req_addr[1:0] != 2'b00);
    assign w_ld_misalign = c_ALIGN_CHECK && (bus.ld_req_addr[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_if_resp_valid <= 1'b0;
            r_if_resp_data  <= '0;
            r_if_resp_err   <= 1'b0;
            r_ld_resp_valid <= 1'b0;
            r_ld_resp_data  <= '0;
            r_ld_resp_err   <= 1'b0;
            r_last_ld       <= 1'b1;
            r_starve        <= '0;
        end else begin
            if (w_gnt_if) begin
                r_if_resp_valid <= 1'b1;
                r_if_resp_data  <= w_if_misalign ? 32'h0 : bus.mem_rdata;
                r_if_resp_err   <= w_if_misalign;
            end else if (bus.if_resp_ready) begin
                r_if_resp_valid <= 1'b0;
            end

            if (w_gnt_ld) begin
                r_ld_resp_valid <= 1'b1;
                r_ld_resp_data  <= w_ld_misalign ? 32'h0 : bus.mem_rdata;
                r_ld_resp_err   <= w_ld_misalign;
            end else if (bus.ld_resp_ready) begin
                r_ld_resp_valid <= 1'b0;
            end

            if (w_gnt_if || w_gnt_ld) begin
                r_last_ld <= w_gnt_ld;
            end

            // A grant implies valid, so a load grant is always a handshake.
            if ((PRIO_MODE == 0) || !bus.ld_req_valid || w_gnt_ld) begin
                r_starve <= '0;
            end else if (r_starve != c_STARVE_MAX) begin
                r_starve <= r_starve + 4'd1;
            end
        end
    end

    assign bus.if_req_ready  = w_gnt_if;
    assign bus.ld_req_ready  = w_gnt_ld;
    assign bus.mem_addr      = w_mem_addr;
    assign bus.if_resp_valid = r_if_resp_valid;
    assign bus.if_resp_data  = r_if_resp_data;
    assign bus.if_resp_err   = r_if_resp_err;
    assign bus.ld_resp_valid = r_ld_resp_valid;
    assign bus.ld_resp_data  = r_ld_resp_data;
    assign bus.ld_resp_err   = r_ld_resp_err;

endmodule

`default_nettype wire

// File: tb/tb_imem_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_imem_arbiter                                              |
// | Description : Bench for imem_arbiter: round-robin (dut0) and fetch-priority|
// |               (dut1) instances against a queue-based reference model.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_imem_arbiter;

    localparam int ADDR_W = 32;
    localparam int LIMIT  = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    imem_arbiter_if #(.ADDR_W(ADDR_W)) bus0 ();
    imem_arbiter_if #(.ADDR_W(ADDR_W)) bus1 ();

    imem_arbiter #(.ADDR_W(ADDR_W), .PRIO_MODE(0), .STARVE_LIMIT(LIMIT)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    imem_arbiter #(.ADDR_W(ADDR_W), .PRIO_MODE(1), .STARVE_LIMIT(LIMIT)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    function automatic logic [31:0] memword(input logic [31:0] a);
        if (a == 32'h8) return 32'h00D00593;
        return (a * 32'h9E3779B1) ^ 32'h6A09E667;
    endfunction

    // Stimulus per instance; index = instance = PRIO_MODE
    logic        t_if_valid [2];
    logic [31:0] t_if_addr  [2];
    logic        t_if_rready[2];
    logic        t_ld_valid [2];
    logic [31:0] t_ld_addr  [2];
    logic        t_ld_rready[2];

    assign bus0.if_req_valid  = t_if_valid[0];
    assign bus0.if_req_addr   = t_if_addr[0];
    assign bus0.if_resp_ready = t_if_rready[0];
    assign bus0.ld_req_valid  = t_ld_valid[0];
    assign bus0.ld_req_addr   = t_ld_addr[0];
    assign bus0.ld_resp_ready = t_ld_rready[0];
    assign bus0.mem_rdata     = memword(bus0.mem_addr);
    assign bus1.if_req_valid  = t_if_valid[1];
    assign bus1.if_req_addr   = t_if_addr[1];
    assign bus1.if_resp_ready = t_if_rready[1];
    assign bus1.ld_req_valid  = t_ld_valid[1];
    assign bus1.ld_req_addr   = t_ld_addr[1];
    assign bus1.ld_resp_ready = t_ld_rready[1];
    assign bus1.mem_rdata     = memword(bus1.mem_addr);

    wire        d_if_ready [2];
    wire        d_ld_ready [2];
    wire [31:0] d_mem_addr [2];
    wire        d_if_rvalid[2];
    wire [31:0] d_if_rdata [2];
    wire        d_if_rerr  [2];
    wire        d_ld_rvalid[2];
    wire [31:0] d_ld_rdata [2];
    wire        d_ld_rerr  [2];

    assign d_if_ready[0]  = bus0.if_req_ready;
    assign d_ld_ready[0]  = bus0.ld_req_ready;
    assign d_mem_addr[0]  = bus0.mem_addr;
    assign d_if_rvalid[0] = bus0.if_resp_valid;
    assign d_if_rdata[0]  = bus0.if_resp_data;
    assign d_if_rerr[0]   = bus0.if_resp_err;
    assign d_ld_rvalid[0] = bus0.ld_resp_valid;
    assign d_ld_rdata[0]  = bus0.ld_resp_data;
    assign d_ld_rerr[0]   = bus0.ld_resp_err;
    assign d_if_ready[1]  = bus1.if_req_ready;
    assign d_ld_ready[1]  = bus1.ld_req_ready;
    assign d_mem_addr[1]  = bus1.mem_addr;
    assign d_if_rvalid[1] = bus1.if_resp_valid;
    assign d_if_rdata[1]  = bus1.if_resp_data;
    assign d_if_rerr[1]   = bus1.if_resp_err;
    assign d_ld_rvalid[1] = bus1.ld_resp_valid;
    assign d_ld_rdata[1]  = bus1.ld_resp_data;
    assign d_ld_rerr[1]   = bus1.ld_resp_err;

    // Reference model: outstanding responses {err,data} per (instance,port)
    logic [32:0] rq [4][$];
    bit          last_ld [2];
    int          starve  [2];
    int          cur_g   [2];
    bit          check_en;
    int          checks   = 0;
    int          failures = 0;

    task automatic chk(input string name, input int m, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d actual=%h required=%h", name, m, act, exp);
        end
    endtask

    function automatic logic [32:0] exp_resp(input logic [31:0] a);
`ifdef IMEM_ARB_ALIGN_CHECK_EN
        if (a[1:0] != 2'b00) return {1'b1, 32'h0};
`endif
        return {1'b0, memword(a)};
    endfunction

    // 0 = none, 1 = fetch, 2 = load
    function automatic int model_grant(input int m);
        bit e_if, e_ld;
        e_if = t_if_valid[m] && (rq[2*m].size() == 0 || t_if_rready[m]);
        e_ld = t_ld_valid[m] && (rq[2*m+1].size() == 0 || t_ld_rready[m]);
        if (e_if && e_ld) begin
            if (m == 0) return last_ld[0] ? 1 : 2;
            return (starve[1] == LIMIT) ? 2 : 1;
        end
        return e_if ? 1 : (e_ld ? 2 : 0);
    endfunction

    task automatic step(input int exp_g0, input int exp_g1);
        int g, ga, eg;
        logic [31:0] ea;
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            g = model_grant(m);
            cur_g[m] = g;
            if (check_en) begin
                ga = (d_if_ready[m] ? 1 : 0) + (d_ld_ready[m] ? 2 : 0);
                eg = (m == 0) ? exp_g0 : exp_g1;
                if (eg >= 0) chk("table_grant", m, ga, eg);
                chk("if_req_ready", m, 32'(d_if_ready[m]), 32'(g == 1));
                chk("ld_req_ready", m, 32'(d_ld_ready[m]), 32'(g == 2));
                ea = (g == 1) ? t_if_addr[m] : ((g == 2) ? t_ld_addr[m] : 32'h0);
                chk("mem_addr", m, d_mem_addr[m], ea);
                chk("if_resp_valid", m, 32'(d_if_rvalid[m]), 32'(rq[2*m].size() != 0));
                chk("ld_resp_valid", m, 32'(d_ld_rvalid[m]), 32'(rq[2*m+1].size() != 0));
                if (rq[2*m].size() != 0) begin
                    chk("if_resp_data", m, d_if_rdata[m], rq[2*m][0][31:0]);
                    chk("if_resp_err", m, 32'(d_if_rerr[m]), 32'(rq[2*m][0][32]));
                end
                if (rq[2*m+1].size() != 0) begin
                    chk("ld_resp_data", m, d_ld_rdata[m], rq[2*m+1][0][31:0]);
                    chk("ld_resp_err", m, 32'(d_ld_rerr[m]), 32'(rq[2*m+1][0][32]));
                end
            end
        end
        for (int m = 0; m < 2; m++) begin
            g = cur_g[m];
            if (!rst_n) begin
                rq[2*m].delete();
                rq[2*m+1].delete();
                last_ld[m] = 1'b1;
                starve[m]  = 0;
            end else begin
                if (rq[2*m].size() != 0 && t_if_rready[m]) void'(rq[2*m].pop_front());
                if (rq[2*m+1].size() != 0 && t_ld_rready[m]) void'(rq[2*m+1].pop_front());
                if (g == 1) rq[2*m].push_back(exp_resp(t_if_addr[m]));
                if (g == 2) rq[2*m+1].push_back(exp_resp(t_ld_addr[m]));
                if (g != 0) last_ld[m] = (g == 2);
                if (m == 1) begin
                    if (t_ld_valid[m] && g != 2) starve[m] = (starve[m] < LIMIT) ? starve[m] + 1 : LIMIT;
                    else starve[m] = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit ifv, input logic [31:0] ifa, input bit ifr,
                         input bit ldv, input logic [31:0] lda, input bit ldr);
        for (int m = 0; m < 2; m++) begin
            t_if_valid[m] = ifv; t_if_addr[m] = ifa; t_if_rready[m] = ifr;
            t_ld_valid[m] = ldv; t_ld_addr[m] = lda; t_ld_rready[m] = ldr;
        end
    endtask

    typedef struct {
        bit ifv; bit ifr; bit ldv; bit ldr; int g0; int g1;
    } vec_t;
    vec_t tbl [13];

    initial begin
        logic [31:0] a;
        logic [32:0] exp_ld6;
        tbl[0]  = '{1, 1, 0, 1, 1, 1};
        tbl[1]  = '{1, 1, 1, 1, 2, 1};
        tbl[2]  = '{1, 1, 1, 1, 1, 1};
        tbl[3]  = '{1, 1, 1, 1, 2, 1};
        tbl[4]  = '{1, 1, 1, 1, 1, 1};
        tbl[5]  = '{1, 1, 1, 1, 2, 2};
        tbl[6]  = '{1, 1, 1, 1, 1, 1};
        tbl[7]  = '{0, 1, 1, 1, 2, 2};
        tbl[8]  = '{0, 1, 0, 1, 0, 0};
        tbl[9]  = '{1, 0, 1, 1, 1, 1};
        tbl[10] = '{1, 0, 1, 1, 2, 2};
        tbl[11] = '{1, 0, 1, 1, 2, 2};
        tbl[12] = '{1, 1, 1, 1, 1, 1};

        rst_n    = 1'b0;
        check_en = 1'b0;
        drive(0, 0, 1, 0, 0, 1);
        @(posedge clk); #1;
        step(-1, -1);
        check_en = 1'b1;
        step(-1, -1);
        for (int m = 0; m < 2; m++) begin
            chk("rst_if_valid", m, 32'(d_if_rvalid[m]), 0);
            chk("rst_ld_valid", m, 32'(d_ld_rvalid[m]), 0);
            chk("rst_if_data", m, d_if_rdata[m], 0);
            chk("rst_ld_data", m, d_ld_rdata[m], 0);
            chk("rst_if_err", m, 32'(d_if_rerr[m]), 0);
        end
        rst_n = 1'b1;

        // Single fetch after reset
        drive(1, 32'h8, 1, 0, 0, 1);
        step(1, 1);
        drive(0, 0, 1, 0, 0, 1);
        for (int m = 0; m < 2; m++) begin
            chk("fetch_valid", m, 32'(d_if_rvalid[m]), 1);
            chk("fetch_data", m, d_if_rdata[m], 32'h00D00593);
            chk("fetch_ld_idle", m, 32'(d_ld_rvalid[m]), 0);
        end
        step(0, 0);

        // Grant pattern table, from reset state
        rst_n = 1'b0;
        step(-1, -1);
        rst_n = 1'b1;
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].ifv, 32'h100 + 32'(i * 4), tbl[i].ifr,
                  tbl[i].ldv, 32'h200 + 32'(i * 4), tbl[i].ldr);
            // keep addresses stable while requests stay pending
            for (int m = 0; m < 2; m++) begin
                t_if_addr[m] = 32'h100;
                t_ld_addr[m] = 32'h200;
            end
            step(tbl[i].g0, tbl[i].g1);
        end

        // Reset the cycle after a handshake
        drive(1, 32'h40, 1, 1, 32'h80, 1);
        step(-1, -1);
        rst_n = 1'b0;
        step(-1, -1);
        rst_n = 1'b1;
        drive(0, 0, 1, 0, 0, 1);
        for (int m = 0; m < 2; m++) begin
            chk("rst_mid_if_valid", m, 32'(d_if_rvalid[m]), 0);
            chk("rst_mid_ld_valid", m, 32'(d_ld_rvalid[m]), 0);
        end
        step(0, 0);
        step(0, 0);

        // Misaligned load
        drive(0, 0, 1, 1, 32'h6, 1);
        step(2, 2);
        drive(0, 0, 1, 0, 0, 1);
`ifdef IMEM_ARB_ALIGN_CHECK_EN
        exp_ld6 = {1'b1, 32'h0};
`else
        exp_ld6 = {1'b0, memword(32'h6)};
`endif
        for (int m = 0; m < 2; m++) begin
            chk("mis_ld_valid", m, 32'(d_ld_rvalid[m]), 1);
            chk("mis_ld_err", m, 32'(d_ld_rerr[m]), 32'(exp_ld6[32]));
            chk("mis_ld_data", m, d_ld_rdata[m], exp_ld6[31:0]);
        end
        step(0, 0);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (!(t_if_valid[m] && cur_g[m] != 1)) begin
                    a = $urandom & 32'h0000FFFC;
                    if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
                    t_if_valid[m] = ($urandom_range(0, 3) != 0);
                    t_if_addr[m]  = a;
                end
                if (!(t_ld_valid[m] && cur_g[m] != 2)) begin
                    a = $urandom & 32'h0000FFFC;
                    if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
                    t_ld_valid[m] = ($urandom_range(0, 2) != 0);
                    t_ld_addr[m]  = a;
                end
                t_if_rready[m] = ($urandom_range(0, 9) < 7);
                t_ld_rready[m] = ($urandom_range(0, 9) < 6);
            end
            rst_n = ($urandom_range(0, 499) != 0);
            step(-1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
